tdm_demux2: RTL
===============

TDM_DEMUX2 -- requirements
Module: tdm_demux2

Interface
REQ-001 SHALL have parameter W, default 4, meaning bits per channel word (legal 1..16).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port din  input  1  serial TDM data line driven by the 2-to-1 multiplexing transmitter.
REQ-005 SHALL have port frm  input  1  frame marker; high only during slot 0 of each frame.
REQ-006 SHALL have port ch0_data  output  W  last complete channel-0 word.
REQ-007 SHALL have port ch1_data  output  W  last complete channel-1 word.
REQ-008 SHALL have port out_valid  output  1  one-cycle pulse when ch0_data/ch1_data update.
REQ-009 SHALL have port locked  output  1  high while the FSM is in LOCK.
REQ-010 SHALL have port frame_err  output  1  one-cycle pulse on each framing violation.
REQ-011 SHALL have port err_cnt  output  8  saturating count of frame_err pulses.

Function
REQ-012 SHALL receive frames of 2W slots, one bit per cycle: slots 0..W-1 are ch0 MSB-first, slots W..2W-1 are ch1 MSB-first.
REQ-013 SHALL implement FSM states HUNT and LOCK with a slot counter 0..2W-1.
REQ-014 In HUNT, SHALL ignore din while frm=0; on frm=1, SHALL capture din as slot 0, set counter to 1, enter LOCK.
REQ-015 In LOCK with counter!=0 and frm=1, SHALL pulse frame_err, discard the partial frame, capture din as slot 0, set counter to 1, stay in LOCK.
REQ-016 In LOCK with counter==0 and frm=0, SHALL pulse frame_err, discard the sample, enter HUNT.
REQ-017 In LOCK with counter==0 and frm=1, SHALL capture slot 0 normally (back-to-back frames, no gap).
REQ-018 On capture of slot 2W-1, SHALL load ch0_data/ch1_data from the shift registers and wrap the counter to 0; outputs and out_valid SHALL be registered, visible the cycle after slot 2W-1 is sampled.
REQ-019 SHALL hold ch0_data/ch1_data unchanged between updates, including across frame errors and HUNT.
REQ-020 err_cnt SHALL increment by 1 per frame_err and saturate at 255.
REQ-021 frame_err and out_valid SHALL never assert in the same cycle; a violation on slot 0 of a frame following a completed one still yields the completed frame's out_valid.

Reset
REQ-022 While reset=1 at a clock edge, SHALL enter HUNT, clear counter and shift registers, and drive ch0_data=0, ch1_data=0, out_valid=0, locked=0, frame_err=0, err_cnt=0.
REQ-023 Reset mid-frame SHALL discard the partial frame with no out_valid and no frame_err.

Configuration
REQ-024 With TDM_DEMUX2_SYNC_EN defined, din and frm SHALL each pass through a two-flop synchronizer before the FSM, adding exactly 2 cycles to every latency; synchronizer flops SHALL clear on reset.
REQ-025 Without TDM_DEMUX2_SYNC_EN, din and frm SHALL feed the FSM directly, with latency per REQ-018.

Structure
REQ-026 SHALL place the state enum (HUNT, LOCK), default W, and err_cnt width (8) in shared package tdm_pkg.
REQ-027 SHALL implement the synchronizer as sub-module sync2 (1-bit, clk/reset, two flops), instantiated once per input when enabled.

Verification
REQ-028 W=4, frm=1000_0000, din=1010_0101, no sync -> ch0_data=4'hA, ch1_data=4'h5, out_valid high exactly one cycle, 1 cycle after 8th bit; locked=1.
REQ-029 Two back-to-back frames (A,5) then (3,C) -> two out_valid pulses 8 cycles apart; final ch0_data=4'h3, ch1_data=4'hC.
REQ-030 frm=1 re-asserted at slot 3 -> frame_err one pulse, err_cnt=1, no out_valid for the aborted frame; new frame from that slot decodes correctly.
REQ-031 frm=0 at expected slot 0 after a good frame -> frame_err pulse, locked=0 next cycle, outputs hold previous values.
REQ-032 Reset asserted at slot 5 -> all outputs 0 next cycle, no out_valid/frame_err; 300 forced violations -> err_cnt=255.
REQ-033 Rerun REQ-028 with TDM_DEMUX2_SYNC_EN -> identical data, out_valid 2 cycles later.

Source files
------------

// File: rtl/tdm_pkg.sv
// ---------------------------------------------------------------------------
// tdm_pkg
//
// Shared definitions for the two-channel TDM demultiplexer:
//   - state_e    : receiver FSM states (HUNT, LOCK)
//   - W_DEFAULT  : default bits per channel word
//   - ERR_CNT_W  : width of the saturating framing-error counter
//   - sat_inc()  : saturating increment used by the error counter
// ---------------------------------------------------------------------------
package tdm_pkg;

  localparam int unsigned W_DEFAULT = 4;
  localparam int unsigned ERR_CNT_W = 8;

  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_e;

  // Increment, but stick at the all-ones value instead of wrapping.
  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    logic [ERR_CNT_W-1:0] r;
    if (v == ERR_CNT_MAX) begin
      r = v;
    end else begin
      r = v + 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sync2.sv
// ---------------------------------------------------------------------------
// sync2
//
// Two-flop synchronizer for a single bit. Both flops clear on reset.
//
// Ports:
//   clk    - clock
//   reset  - synchronous, active-high reset
//   i_d    - asynchronous input bit
//   o_q    - synchronized output (two cycles of latency)
// ---------------------------------------------------------------------------
module sync2 (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/tdm_demux2.sv
// ---------------------------------------------------------------------------
// tdm_demux2
//
// Receiver for a 2-to-1 bit-serial TDM stream. Each frame is 2*W slots, one
// bit per cycle: slots 0..W-1 carry channel 0 MSB-first, slots W..2W-1 carry
// channel 1 MSB-first. The frame marker frm is high only during slot 0.
//
// A HUNT/LOCK FSM with a slot counter tracks framing. A completed frame loads
// both channel words and pulses out_valid one cycle after the last slot is
// sampled. Any framing violation pulses frame_err and bumps a saturating
// error counter; the channel words are held across errors and HUNT.
//
// Build option:
//   TDM_DEMUX2_SYNC_EN - when defined, din and frm each pass through a
//                        two-flop synchronizer (sync2) before the FSM, adding
//                        two cycles to every latency. Undefined by default.
//
// Ports:
//   clk        - sole clock, rising edge
//   reset      - synchronous, active-high reset
//   din        - serial TDM data
//   frm        - frame marker (high in slot 0)
//   ch0_data   - last complete channel-0 word (W bits)
//   ch1_data   - last complete channel-1 word (W bits)
//   out_valid  - one-cycle pulse when ch0_data/ch1_data update
//   locked     - high while the FSM is in LOCK
//   frame_err  - one-cycle pulse per framing violation
//   err_cnt    - saturating count of frame_err pulses
// ---------------------------------------------------------------------------
module tdm_demux2
  import tdm_pkg::*;
#(
  parameter int unsigned W = W_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 din,
  input  logic                 frm,
  output logic [W-1:0]         ch0_data,
  output logic [W-1:0]         ch1_data,
  output logic                 out_valid,
  output logic                 locked,
  output logic                 frame_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int unsigned     SLOTS     = 2 * W;
  localparam int unsigned     CW        = $clog2(SLOTS);
  localparam logic [CW-1:0]   LAST_SLOT = CW'(SLOTS - 1);
  localparam logic [CW-1:0]   FIRST_CNT = CW'(1);

  // -------------------------------------------------------------------------
  // Input conditioning
  // -------------------------------------------------------------------------
  logic w_din;
  logic w_frm;

`ifdef TDM_DEMUX2_SYNC_EN
  sync2 u_sync_din (
    .clk   (clk),
    .reset (reset),
    .i_d   (din),
    .o_q   (w_din)
  );

  sync2 u_sync_frm (
    .clk   (clk),
    .reset (reset),
    .i_d   (frm),
    .o_q   (w_frm)
  );
`else
  assign w_din = din;
  assign w_frm = frm;
`endif

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_e               r_state;
  logic [CW-1:0]        r_cnt;
  logic [SLOTS-1:0]     r_sr;
  logic [W-1:0]         r_ch0;
  logic [W-1:0]         r_ch1;
  logic                 r_valid;
  logic                 r_err;
  logic [ERR_CNT_W-1:0] r_err_cnt;

  // One shift register holds the whole frame; ch0 ends up in the upper half
  // because it is shifted in first.
  logic [SLOTS-1:0] w_sr_next;
  logic [SLOTS-1:0] w_sr_first;

  assign w_sr_next  = {r_sr[SLOTS-2:0], w_din};
  assign w_sr_first = {{(SLOTS-1){1'b0}}, w_din};

  // -------------------------------------------------------------------------
  // Framing FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= HUNT;
      r_cnt     <= '0;
      r_sr      <= '0;
      r_ch0     <= '0;
      r_ch1     <= '0;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;

      unique case (r_state)
        HUNT: begin
          // Data is ignored until the first frame marker.
          if (w_frm) begin
            r_sr    <= w_sr_first;
            r_cnt   <= FIRST_CNT;
            r_state <= LOCK;
          end
        end

        LOCK: begin
          if (w_frm) begin
            // A marker anywhere but slot 0 aborts the partial frame; the
            // marker itself still starts a fresh frame, so we stay locked.
            if (r_cnt != '0) begin
              r_err     <= 1'b1;
              r_err_cnt <= sat_inc(r_err_cnt);
            end
            r_sr  <= w_sr_first;
            r_cnt <= FIRST_CNT;
          end else if (r_cnt == '0) begin
            // Expected a marker and did not see one: lose lock.
            r_err     <= 1'b1;
            r_err_cnt <= sat_inc(r_err_cnt);
            r_state   <= HUNT;
          end else begin
            r_sr <= w_sr_next;
            if (r_cnt == LAST_SLOT) begin
              r_ch0   <= w_sr_next[SLOTS-1:W];
              r_ch1   <= w_sr_next[W-1:0];
              r_valid <= 1'b1;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end

        default: begin
          r_state <= HUNT;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign ch0_data  = r_ch0;
  assign ch1_data  = r_ch1;
  assign out_valid = r_valid;
  assign locked    = (r_state == LOCK);
  assign frame_err = r_err;
  assign err_cnt   = r_err_cnt;

endmodule
